// File: rtl/dotp_feeder.sv
// dotp_feeder: buffers operand pairs from the core, streams a programmed number of them into dotp as
// one contiguous load burst, captures the dot product and hands it back with a valid/ack handshake.
// Optional watchdog on the dotp_ready wait: define DOTP_FEEDER_TIMEOUT_EN.
module dotp_feeder #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 8,
    parameter int CNT_W = $clog2(DEPTH) + 1
`ifdef DOTP_FEEDER_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYC = 64
`endif
) (
    input  logic             clk_half,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [XLEN-1:0]  wr_a,
    input  logic [XLEN-1:0]  wr_b,
    output logic             full,
    output logic [CNT_W-1:0] count,
    input  logic             start,
    input  logic [CNT_W-1:0] len,
    output logic             start_rej,
    output logic             busy,
    output logic             res_valid,
    output logic [XLEN-1:0]  result,
    input  logic             res_ack,
    output logic             err,
    output logic             dotp_load,
    output logic             dotp_enable,
    output logic [XLEN-1:0]  dotp_a,
    output logic [XLEN-1:0]  dotp_b,
    input  logic [XLEN-1:0]  dotp_out,
    input  logic             dotp_ready
);
    localparam int AW = $clog2(DEPTH);
    typedef enum logic [2:0] {IDLE, LOAD, WAIT, CAPT, RESULT} state_t;
    state_t state;
    logic [XLEN-1:0] mem_a [DEPTH];
    logic [XLEN-1:0] mem_b [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0] rem;
    logic push, pop;
    assign full = count == CNT_W'(DEPTH);
    assign push = wr_en && !full;
    assign pop = state == LOAD;
    assign busy = state != IDLE;
    assign res_valid = state == RESULT;
`ifdef DOTP_FEEDER_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
    logic [WD_W-1:0] wd;
`else
    assign err = 1'b0;
`endif
    // operand storage, written whenever there is room
    always_ff @(posedge clk_half)
        if (push) begin
            mem_a[wr_ptr] <= wr_a;
            mem_b[wr_ptr] <= wr_b;
        end
    // FIFO pointers and occupancy; a simultaneous push and pop leaves count unchanged
    always_ff @(posedge clk_half) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end
    // sequencer: load burst, wait for ready, capture, hold result until acknowledged
    always_ff @(posedge clk_half) begin
        if (rst) begin
            state <= IDLE;
            rem <= '0;
            start_rej <= 1'b0;
            result <= '0;
            dotp_load <= 1'b0;
            dotp_enable <= 1'b0;
            dotp_a <= '0;
            dotp_b <= '0;
`ifdef DOTP_FEEDER_TIMEOUT_EN
            wd <= '0;
            err <= 1'b0;
`endif
        end else begin
            start_rej <= 1'b0;
            dotp_load <= 1'b0;
            dotp_a <= '0;
            dotp_b <= '0;
            case (state)
                IDLE: begin
                    dotp_enable <= 1'b0;
                    if (start && len != '0 && len <= count) begin
                        rem <= len;
                        state <= LOAD;
`ifdef DOTP_FEEDER_TIMEOUT_EN
                        err <= 1'b0;
`endif
                    end else if (start) begin
                        start_rej <= 1'b1;
                    end
                end
                LOAD: begin
                    dotp_load <= 1'b1;
                    dotp_enable <= 1'b1;
                    dotp_a <= mem_a[rd_ptr];
                    dotp_b <= mem_b[rd_ptr];
                    rem <= rem - 1'b1;
                    if (rem == CNT_W'(1)) state <= WAIT;
`ifdef DOTP_FEEDER_TIMEOUT_EN
                    wd <= '0;
`endif
                end
                WAIT: begin
                    dotp_enable <= 1'b1;
                    if (dotp_ready) state <= CAPT;
`ifdef DOTP_FEEDER_TIMEOUT_EN
                    else if (wd == WD_W'(TIMEOUT_CYC - 1)) begin
                        err <= 1'b1;
                        dotp_enable <= 1'b0;
                        result <= '0;
                        state <= RESULT;
                    end else wd <= wd + 1'b1;
`endif
                end
                CAPT: begin
                    result <= dotp_out;
                    dotp_enable <= 1'b0;
                    state <= RESULT;
                end
                RESULT: begin
                    dotp_enable <= 1'b0;
                    if (res_ack) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dotp_feeder.sv
// tb_dotp_feeder: directed checks of the dotp_feeder FIFO, load burst, rejection, reset and watchdog
module tb_dotp_feeder;
    localparam int XLEN = 32;
    localparam int DEPTH = 8;
    localparam int CNT_W = 4;
    logic clk_half = 1'b0;
    logic rst = 1'b1;
    logic wr_en = 1'b0;
    logic start = 1'b0;
    logic res_ack = 1'b0;
    logic dotp_ready = 1'b0;
    logic [XLEN-1:0] wr_a = '0;
    logic [XLEN-1:0] wr_b = '0;
    logic [XLEN-1:0] dotp_out = '0;
    logic [CNT_W-1:0] len = '0;
    logic full, start_rej, busy, res_valid, err, dotp_load, dotp_enable;
    logic [CNT_W-1:0] count;
    logic [XLEN-1:0] result, dotp_a, dotp_b;
    int n_cmp = 0;
    int n_bad = 0;
    int nload = 0;
    int nruns = 0;
    int lbase = 0;
    int rbase = 0;
    logic prev_load = 1'b0;
    logic [XLEN-1:0] la [64];
    logic [XLEN-1:0] lb [64];

    always #5 clk_half = ~clk_half;

    dotp_feeder #(
        .XLEN(XLEN),
        .DEPTH(DEPTH),
        .CNT_W(CNT_W)
`ifdef DOTP_FEEDER_TIMEOUT_EN
        ,
        .TIMEOUT_CYC(16)
`endif
    ) dut (
        .clk_half(clk_half),
        .rst(rst),
        .wr_en(wr_en),
        .wr_a(wr_a),
        .wr_b(wr_b),
        .full(full),
        .count(count),
        .start(start),
        .len(len),
        .start_rej(start_rej),
        .busy(busy),
        .res_valid(res_valid),
        .result(result),
        .res_ack(res_ack),
        .err(err),
        .dotp_load(dotp_load),
        .dotp_enable(dotp_enable),
        .dotp_a(dotp_a),
        .dotp_b(dotp_b),
        .dotp_out(dotp_out),
        .dotp_ready(dotp_ready)
    );

    // record every pair dotp sees and count separate load bursts
    always @(posedge clk_half) begin
        if (dotp_load) begin
            la[6'(nload)] = dotp_a;
            lb[6'(nload)] = dotp_b;
            nload = nload + 1;
            if (!prev_load) nruns = nruns + 1;
        end
        prev_load = dotp_load;
    end

    task automatic tick;
        @(posedge clk_half);
        #1;
    endtask

    task automatic chk(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
        wr_en = 1'b1;
        wr_a = a;
        wr_b = b;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic do_start(input int n);
        lbase = nload;
        rbase = nruns;
        start = 1'b1;
        len = CNT_W'(n);
        tick();
        start = 1'b0;
    endtask

    task automatic wait_loads(input int n);
        int t = 0;
        while (!((nload - lbase) == n && !dotp_load) && t < 40) begin
            tick();
            t++;
        end
        chk("load_done", 32'(t < 40), 32'd1);
        chk("load_count", 32'(nload - lbase), 32'(n));
        chk("load_bursts", 32'(nruns - rbase), 32'd1);
        chk("enable_in_wait", 32'(dotp_enable), 32'd1);
    endtask

    task automatic chk_pair(input int i, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
        chk("pair_a", la[6'(lbase + i)], a);
        chk("pair_b", lb[6'(lbase + i)], b);
    endtask

    task automatic finish_run(input logic [XLEN-1:0] res);
        int t = 0;
        dotp_out = res;
        dotp_ready = 1'b1;
        tick();
        dotp_ready = 1'b0;
        while (!res_valid && t < 20) begin
            tick();
            t++;
        end
        chk("res_valid", 32'(res_valid), 32'd1);
        chk("result", result, res);
        chk("enable_in_result", 32'(dotp_enable), 32'd0);
        start = 1'b1;
        len = CNT_W'(1);
        tick();
        start = 1'b0;
        chk("start_ignored_rej", 32'(start_rej), 32'd0);
        chk("start_ignored_valid", 32'(res_valid), 32'd1);
        res_ack = 1'b1;
        tick();
        res_ack = 1'b0;
        chk("ack_clears_valid", 32'(res_valid), 32'd0);
        chk("ack_idle", 32'(busy), 32'd0);
    endtask

    initial begin
        tick();
        tick();
        rst = 1'b0;
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_valid", 32'(res_valid), 32'd0);
        chk("rst_result", result, 32'd0);
        chk("rst_rej", 32'(start_rej), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_load", 32'(dotp_load), 32'd0);
        chk("rst_enable", 32'(dotp_enable), 32'd0);
        chk("rst_a", dotp_a, 32'd0);
        // single pair: 2.0 * 3.0 = 6.0
        push(32'h4000_0000, 32'h4040_0000);
        chk("one_count", 32'(count), 32'd1);
        do_start(1);
        chk("one_busy", 32'(busy), 32'd1);
        wait_loads(1);
        chk_pair(0, 32'h4000_0000, 32'h4040_0000);
        chk("one_load_zero_a", dotp_a, 32'd0);
        finish_run(32'h40C0_0000);
        chk("one_count_end", 32'(count), 32'd0);
        // two pairs: 1*3 + 2*4 = 11.0
        push(32'h3F80_0000, 32'h4040_0000);
        push(32'h4000_0000, 32'h4080_0000);
        do_start(2);
        wait_loads(2);
        chk_pair(0, 32'h3F80_0000, 32'h4040_0000);
        chk_pair(1, 32'h4000_0000, 32'h4080_0000);
        finish_run(32'h4130_0000);
        chk("two_count_end", 32'(count), 32'd0);
        // rejection with two pairs buffered
        push(32'h3F80_0000, 32'h3F80_0000);
        push(32'h4000_0000, 32'h3F80_0000);
        start = 1'b1;
        len = CNT_W'(3);
        tick();
        start = 1'b0;
        chk("rej_len3", 32'(start_rej), 32'd1);
        chk("rej_busy", 32'(busy), 32'd0);
        tick();
        chk("rej_pulse_end", 32'(start_rej), 32'd0);
        chk("rej_count", 32'(count), 32'd2);
        start = 1'b1;
        len = CNT_W'(0);
        tick();
        start = 1'b0;
        chk("rej_len0", 32'(start_rej), 32'd1);
        chk("rej_busy0", 32'(busy), 32'd0);
        tick();
        chk("rej0_pulse_end", 32'(start_rej), 32'd0);
        // the untouched FIFO still yields 1*1 + 2*1 = 3.0
        do_start(2);
        wait_loads(2);
        chk_pair(0, 32'h3F80_0000, 32'h3F80_0000);
        chk_pair(1, 32'h4000_0000, 32'h3F80_0000);
        finish_run(32'h4040_0000);
        // FIFO boundary: ninth push is dropped
        for (int i = 0; i < DEPTH + 1; i++) begin
            push(32'h1000_0000 + 32'(i), 32'h2000_0000 + 32'(i));
            chk("fill_full", 32'(full), 32'(i >= DEPTH - 1));
            chk("fill_count", 32'(count), 32'(i < DEPTH ? i + 1 : DEPTH));
        end
        do_start(8);
        tick();
        push(32'hABCD_0001, 32'hABCD_0002);
        wait_loads(8);
        chk("burst_count_end", 32'(count), 32'd1);
        for (int i = 0; i < DEPTH; i++) chk_pair(i, 32'h1000_0000 + 32'(i), 32'h2000_0000 + 32'(i));
        finish_run(32'h4200_0000);
        chk("after_burst_count", 32'(count), 32'd1);
        // reset while waiting for ready
        do_start(1);
        wait_loads(1);
        chk_pair(0, 32'hABCD_0001, 32'hABCD_0002);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_enable", 32'(dotp_enable), 32'd0);
        chk("mid_rst_count", 32'(count), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_valid", 32'(res_valid), 32'd0);
        chk("mid_rst_result", result, 32'd0);
        chk("mid_rst_load", 32'(dotp_load), 32'd0);
        push(32'h4000_0000, 32'h4040_0000);
        do_start(1);
        wait_loads(1);
        chk_pair(0, 32'h4000_0000, 32'h4040_0000);
        finish_run(32'h40C0_0000);
`ifdef DOTP_FEEDER_TIMEOUT_EN
        begin
            int t = 0;
            push(32'h4000_0000, 32'h4040_0000);
            dotp_out = 32'h4444_4444;
            do_start(1);
            wait_loads(1);
            while (!res_valid && t < 40) begin
                tick();
                t++;
            end
            chk("to_wait_cycles", 32'(t), 32'd15);
            chk("to_err", 32'(err), 32'd1);
            chk("to_valid", 32'(res_valid), 32'd1);
            chk("to_result", result, 32'd0);
            chk("to_enable", 32'(dotp_enable), 32'd0);
            res_ack = 1'b1;
            tick();
            res_ack = 1'b0;
            chk("to_err_sticky", 32'(err), 32'd1);
            push(32'h3F80_0000, 32'h3F80_0000);
            do_start(1);
            chk("to_err_cleared", 32'(err), 32'd0);
            wait_loads(1);
            finish_run(32'h3F80_0000);
        end
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/dotp_feeder.md
Name: dotp_feeder

Overview:
- Initiator-side sequencer for the floating-point dot-product unit (dotp).
- Buffers operand pairs written by the core into an internal FIFO.
- On a start command, streams a programmed number of pairs into dotp as one contiguous load burst, holds enable until dotp signals ready, and captures the result.
- Presents the result to the core with a valid/ack handshake.
- Sits between the core-side accelerator register interface and dotp, on the half-rate clock domain.

Parameters:
- XLEN, 32, operand/result width (IEEE-754 single).
- DEPTH, 8, FIFO depth in operand pairs; power of two, >= 2.
- CNT_W, $clog2(DEPTH)+1, width of count/len fields.
- TIMEOUT_CYC, 64, watchdog limit in cycles (used only with the optional feature).

Ports:
- clk_half  in  1  block clock, shared with dotp.
- rst  in  1  synchronous active-high reset.
- wr_en  in  1  push {wr_a, wr_b} into the FIFO.
- wr_a  in  XLEN  operand A.
- wr_b  in  XLEN  operand B.
- full  out  1  FIFO full.
- count  out  CNT_W  pairs currently buffered.
- start  in  1  begin a dot product of len pairs.
- len  in  CNT_W  number of pairs, 1..DEPTH.
- start_rej  out  1  one-cycle pulse: start was rejected.
- busy  out  1  high in every state except IDLE.
- res_valid  out  1  result available.
- result  out  XLEN  captured dot product.
- res_ack  in  1  core consumed the result.
- err  out  1  watchdog error flag; tied 0 without the optional feature.
- dotp_load  out  1  to dotp load.
- dotp_enable  out  1  to dotp enable.
- dotp_a  out  XLEN  to dotp buf_a.
- dotp_b  out  XLEN  to dotp buf_b.
- dotp_out  in  XLEN  from dotp out.
- dotp_ready  in  1  from dotp ready.

Behaviour:
- Clock and reset: one clock (clk_half). Reset (rst) is synchronous and active-high.
- Reset values: all outputs 0, FIFO emptied, FSM in IDLE. Reset mid-operation aborts immediately; dotp_enable falls to 0 on the next edge, which clears dotp's internal state.
- All dotp_* outputs are registered.
- FIFO:
  - Push when wr_en && !full; wr_en while full is dropped and count is unchanged.
  - Pop occurs only in LOAD.
  - Simultaneous push and pop: count unchanged, both take effect.
  - Pointers wrap modulo DEPTH.
  - Writes are accepted in any state.
- FSM states: IDLE, LOAD, WAIT, CAPT, RESULT.
- IDLE:
  - dotp_enable=0.
  - start with 1<=len<=count: latch rem=len, go to LOAD.
  - start with len==0 or len>count: pulse start_rej for 1 cycle, stay in IDLE.
  - start outside IDLE is ignored, with no start_rej.
- LOAD:
  - Each cycle, register the FIFO head into dotp_a/dotp_b, set dotp_load=1, pop, decrement rem.
  - Exactly len consecutive cycles with dotp_load=1, no gaps.
  - dotp_enable=1 from the first LOAD cycle onward.
  - When rem reaches 0, go to WAIT; dotp_load, dotp_a and dotp_b are driven 0 from then on.
- WAIT:
  - dotp_enable=1, dotp_load=0.
  - dotp_ready=1: go to CAPT.
- CAPT:
  - dotp_enable remains 1 for this cycle, because dotp updates its out register on the edge following ready.
  - At the end of CAPT, result<=dotp_out and go to RESULT.
- RESULT:
  - res_valid=1, result stable, dotp_enable=0.
  - res_ack: res_valid drops on the next edge, go to IDLE.
  - res_ack outside RESULT is ignored.
- Back-to-back: a start in the cycle after the return to IDLE is accepted if the FIFO holds enough pairs.
- busy=1 in LOAD, WAIT, CAPT, RESULT.

Optional Feature:
- Macro: DOTP_FEEDER_TIMEOUT_EN.
- Defined:
  - A watchdog counter resets on WAIT entry and increments each WAIT cycle.
  - Reaching TIMEOUT_CYC without dotp_ready: set err=1 (sticky until the next accepted start or rst), drive dotp_enable=0, result=0, go to RESULT with res_valid=1.
- Undefined: no counter logic; err tied 0; WAIT waits indefinitely.

Test Plan:
- Single pair: push (40000000,40400000); start len=1 -> exactly 1 dotp_load cycle; res_valid with result=40C00000 (6.0); res_ack clears it.
- Two pairs: push (3F800000,40400000), (40000000,40800000); start len=2 -> 2 contiguous load cycles; result=41300000 (11.0); count returns to 0.
- Rejection: count=2, start len=3 -> start_rej pulses 1 cycle, busy stays 0, FIFO untouched. Then start len=0 -> start_rej pulses again.
- FIFO boundary: push DEPTH+1 pairs -> full=1 after the 8th push, 9th dropped, count=8. Start len=8 while pushing 1 more during LOAD -> count ends at 1.
- Reset mid-WAIT: assert rst 1 cycle -> next cycle all outputs 0, count=0, dotp_enable=0. A fresh single-pair run afterwards gives the correct result.
- With DOTP_FEEDER_TIMEOUT_EN, TIMEOUT_CYC=16, bench holds dotp_ready=0 -> after 16 WAIT cycles err=1, res_valid=1, result=0. The next accepted start clears err.
